// File: rtl/fetcher.sv
// Instruction fetch unit: one outstanding word fetch, next-PC prediction and a circular instruction
// queue read combinationally at the head. Define PREDICTOR_BHT_EN for the 2-bit-counter predictor.
module fetcher #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter int unsigned BHT_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_valid,
    input  logic [31:0] in_mem_inst,

    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_jump_flag,
    input  logic        in_dispatch_ready,

    input  logic        in_rob_clear,
    input  logic [31:0] in_rob_target_pc,

    input  logic        in_bht_update_valid,
    input  logic [31:0] in_bht_update_pc,
    input  logic        in_bht_update_taken
);

    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] IQ_FULL = CNT_W'(IQ_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             discard_q;

    logic [31:0] iq_inst_q [IQ_DEPTH];
    logic [31:0] iq_pc_q   [IQ_DEPTH];
    logic        iq_jump_q [IQ_DEPTH];

    // Prediction from the returning word

    logic [6:0]  opcode;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_branch;
    logic        br_taken;
    logic        pred;
    logic [31:0] next_pc;

    assign opcode    = in_mem_inst[6:0];
    assign is_jal    = (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BRANCH);
    assign j_imm     = {{12{in_mem_inst[31]}}, in_mem_inst[19:12], in_mem_inst[20],
                        in_mem_inst[30:21], 1'b0};
    assign b_imm     = {{20{in_mem_inst[31]}}, in_mem_inst[7], in_mem_inst[30:25],
                        in_mem_inst[11:8], 1'b0};

    always_comb begin
        pred    = 1'b0;
        next_pc = pc_q + 32'd4;
        if (is_jal) begin
            pred    = 1'b1;
            next_pc = pc_q + j_imm;
        end else if (is_branch && br_taken) begin
            pred    = 1'b1;
            next_pc = pc_q + b_imm;
        end
    end

`ifdef PREDICTOR_BHT_EN
    localparam int unsigned BHT_SIZE = 2 ** BHT_BITS;

    logic [1:0]          bht_q [BHT_SIZE];
    logic [BHT_BITS-1:0] bht_rd_idx;
    logic [BHT_BITS-1:0] bht_wr_idx;
    logic [1:0]          bht_wr_old;

    assign bht_rd_idx = pc_q[BHT_BITS+1:2];
    assign bht_wr_idx = in_bht_update_pc[BHT_BITS+1:2];
    assign bht_wr_old = bht_q[bht_wr_idx];
    // Registered table: a same-cycle update to the looked-up index is seen only next cycle.
    assign br_taken   = bht_q[bht_rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_SIZE; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy && in_bht_update_valid) begin
            if (in_bht_update_taken) begin
                if (bht_wr_old != 2'b11) bht_q[bht_wr_idx] <= bht_wr_old + 2'b01;
            end else begin
                if (bht_wr_old != 2'b00) bht_q[bht_wr_idx] <= bht_wr_old - 2'b01;
            end
        end
    end

    logic unused_bht_pc;
    assign unused_bht_pc = ^{in_bht_update_pc[31:BHT_BITS+2], in_bht_update_pc[1:0]};
`else
    // Static rule: backward branches taken.
    assign br_taken = b_imm[31];

    localparam int unsigned UNUSED_BHT_BITS = BHT_BITS;
    logic unused_bht;
    assign unused_bht = ^{in_bht_update_valid, in_bht_update_pc, in_bht_update_taken};
`endif

    // Instruction queue

    logic do_push;
    logic do_pop;

    assign out_valid     = (count_q != '0);
    assign out_inst      = iq_inst_q[head_q];
    assign out_pc        = iq_pc_q[head_q];
    assign out_jump_flag = iq_jump_q[head_q];

    assign do_push = (state_q == StWait) && in_mem_valid && !discard_q && !in_rob_clear;
    assign do_pop  = out_valid && in_dispatch_ready && !in_rob_clear;

    always_ff @(posedge clk) begin
        if (!rst && rdy && do_push) begin
            iq_inst_q[tail_q] <= in_mem_inst;
            iq_pc_q[tail_q]   <= pc_q;
            iq_jump_q[tail_q] <= pred;
        end
    end

    // Fetch FSM, pointers and count

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            discard_q    <= 1'b0;
            out_mem_req  <= 1'b0;
            out_mem_addr <= '0;
        end else if (rdy) begin
            if (in_rob_clear) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                pc_q    <= in_rob_target_pc;
                if (state_q == StWait) begin
                    if (in_mem_valid) begin
                        state_q     <= StIdle;
                        out_mem_req <= 1'b0;
                        discard_q   <= 1'b0;
                    end else begin
                        // The outstanding fetch cannot be cancelled; drop it when it lands.
                        discard_q <= 1'b1;
                    end
                end
            end else begin
                if (do_push) tail_q <= tail_q + PTR_W'(1);
                if (do_pop)  head_q <= head_q + PTR_W'(1);
                if (do_push && !do_pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!do_push && do_pop) begin
                    count_q <= count_q - CNT_W'(1);
                end

                unique case (state_q)
                    StIdle: begin
                        if (count_q < IQ_FULL) begin
                            state_q      <= StWait;
                            out_mem_req  <= 1'b1;
                            out_mem_addr <= pc_q;
                        end
                    end
                    StWait: begin
                        if (in_mem_valid) begin
                            state_q     <= StIdle;
                            out_mem_req <= 1'b0;
                            discard_q   <= 1'b0;
                            if (!discard_q) pc_q <= next_pc;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
